lsu_subword: RTL

- Load/store unit between the core datapath and the word-only data memory.
- The memory has a combinational word read and a registered word write.
- Converts byte, halfword and word loads/stores into aligned word accesses:
  - sub-word loads: lane extraction plus sign or zero extension;
  - sub-word stores: single-cycle read-merge-write.
- Detects misaligned and unsupported accesses and reports them as errors without touching memory.

---
 rtl/lsu_subword.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lsu_subword.sv
// Load/store unit: turns byte/halfword/word core accesses into aligned word
// accesses on a combinational-read, registered-write data memory.
module lsu_subword #(
    parameter int unsigned ADDR_W        = 32,
    parameter bit          ERR_ON_BAD_F3 = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_RESP} state_t;

    state_t              r_state, w_next;
    logic                r_we, r_err;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata, r_rdata;

    logic                w_accept, w_f3_ok, w_misalign, w_err;
    logic [2:0]          w_f3_eff;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data, w_store_data;
    logic [ADDR_W-1:0]   w_addr_al;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_addr_al = {r_addr[ADDR_W-1:2], 2'b00};

    // Unsupported codes fall back to a word access when they are not flagged.
    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !req_we;
            default:                w_f3_ok = 1'b0;
        endcase
        w_f3_eff   = (w_f3_ok || ERR_ON_BAD_F3) ? req_funct3 : 3'b010;
        w_misalign = ((w_f3_eff[1:0] == 2'b01) && req_addr[0]) ||
                     (w_f3_eff[1] && (req_addr[1:0] != 2'b00));
        w_err      = w_misalign || (!w_f3_ok && ERR_ON_BAD_F3);
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rd;
        endcase
    end

    always_comb begin
        w_store_data = mem_rd;
        case (r_funct3[1:0])
            2'b00: begin
                case (r_addr[1:0])
                    2'd0:    w_store_data[7:0]   = r_wdata[7:0];
                    2'd1:    w_store_data[15:8]  = r_wdata[7:0];
                    2'd2:    w_store_data[23:16] = r_wdata[7:0];
                    default: w_store_data[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) w_store_data[31:16] = r_wdata[15:0];
                else           w_store_data[15:0]  = r_wdata[15:0];
            end
            default: w_store_data = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)       w_next = S_RESP;
                    else if (req_we) w_next = S_STORE;
                    else             w_next = S_LOAD;
                end
            end
            S_LOAD:  w_next = S_RESP;
            S_STORE: w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        resp_err   = (r_state == S_RESP) && r_err;
        resp_rdata = (r_state == S_RESP && !r_we && !r_err) ? r_rdata : '0;
        mem_we     = (r_state == S_STORE);
        mem_a      = (r_state == S_LOAD || r_state == S_STORE) ? w_addr_al : '0;
        mem_wd     = (r_state == S_STORE) ? w_store_data : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_err    <= w_err;
            r_funct3 <= w_f3_eff;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
        end else if (r_state == S_LOAD) begin
            r_rdata  <= w_load_data;
        end
    end

endmodule
